// File: rtl/dma_ctrl_if.sv
// dma_ctrl_if: slave register strobes plus bus-master handshake and strobes of the DMA engine.
interface dma_ctrl_if;
    logic [7:0]  addr;
    logic        cs_;
    logic        oe_;
    logic        we_;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] m_addr;
    logic        m_cs_;
    logic        m_oe_;
    logic        m_we_;
    logic [7:0]  m_wdata;
    logic        m_drive;
    logic [7:0]  m_rdata;
    logic        irq;
    modport slave (
        input  addr, cs_, oe_, we_, bus_gnt, m_rdata,
        output bus_req, m_addr, m_cs_, m_oe_, m_we_, m_wdata, m_drive, irq
    );
    modport master (
        output addr, cs_, oe_, we_, bus_gnt, m_rdata,
        input  bus_req, m_addr, m_cs_, m_oe_, m_we_, m_wdata, m_drive, irq
    );
endinterface

// File: rtl/dma_ctrl.sv
// dma_ctrl: single-channel byte DMA bus master, configured through a memory-mapped slave port.
module dma_ctrl #(
    parameter int unsigned RD_WAIT = 1,
    parameter int unsigned WR_WAIT = 0
) (
    input  logic      clk,
    input  logic      rst_,
    inout  wire [7:0] data,
    dma_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, RD, WR, WR_HOLD, NEXT, RELEASE} state_t;
    state_t      r_state;
    logic [31:0] r_src, r_dst, r_m_addr, w_src_nx, w_dst_nx;
    logic [15:0] r_len;
    logic [7:0]  r_cnt, r_m_wdata, w_rdata;
    logic        r_irq_en, r_src_fixed, r_dst_fixed, r_busy, r_done, r_irq, r_wr_d;
    logic        r_bus_req, r_m_cs_, r_m_oe_, r_m_we_, r_m_drive;
    logic        w_wr, w_wr_pulse;

    assign w_wr       = ~bus.cs_ & ~bus.we_;
    assign w_wr_pulse = w_wr & ~r_wr_d;
    assign w_src_nx   = r_src_fixed ? r_src : r_src + 32'd1;
    assign w_dst_nx   = r_dst_fixed ? r_dst : r_dst + 32'd1;
    assign w_rdata    = (bus.addr[7:2] == 6'd0) ? r_src[{bus.addr[1:0], 3'b000} +: 8] :
                        (bus.addr[7:2] == 6'd1) ? r_dst[{bus.addr[1:0], 3'b000} +: 8] :
                        (bus.addr == 8'h08)     ? r_len[7:0] :
                        (bus.addr == 8'h09)     ? r_len[15:8] :
                        (bus.addr == 8'h0A)     ? {4'h0, r_dst_fixed, r_src_fixed, r_irq_en, 1'b0} :
                        (bus.addr == 8'h0B)     ? {6'h0, r_done, r_busy} : 8'h00;
    assign data        = (~bus.cs_ & ~bus.oe_) ? w_rdata : 8'hzz;
    assign bus.bus_req = r_bus_req;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_cs_   = r_m_cs_;
    assign bus.m_oe_   = r_m_oe_;
    assign bus.m_we_   = r_m_we_;
    assign bus.m_wdata = r_m_wdata;
    assign bus.m_drive = r_m_drive;
    assign bus.irq     = r_irq;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state     <= IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_irq_en    <= 1'b0;
            r_src_fixed <= 1'b0;
            r_dst_fixed <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_irq       <= 1'b0;
            r_wr_d      <= 1'b0;
            r_bus_req   <= 1'b0;
            r_m_addr    <= '0;
            r_m_cs_     <= 1'b1;
            r_m_oe_     <= 1'b1;
            r_m_we_     <= 1'b1;
            r_m_wdata   <= '0;
            r_m_drive   <= 1'b0;
        end else begin
            r_wr_d <= w_wr;
            r_irq  <= r_done & r_irq_en;
            if (w_wr_pulse) begin
                if (bus.addr[7:2] == 6'd0 && !r_busy) r_src[{bus.addr[1:0], 3'b000} +: 8] <= data;
                if (bus.addr[7:2] == 6'd1 && !r_busy) r_dst[{bus.addr[1:0], 3'b000} +: 8] <= data;
                if (bus.addr == 8'h08 && !r_busy) r_len[7:0] <= data;
                if (bus.addr == 8'h09 && !r_busy) r_len[15:8] <= data;
                if (bus.addr == 8'h0B && data[1]) r_done <= 1'b0;
                if (bus.addr == 8'h0A) begin
                    r_irq_en <= data[1];
                    if (!r_busy) begin
                        r_src_fixed <= data[2];
                        r_dst_fixed <= data[3];
                        if (data[0] && r_len == 16'd0) r_done <= 1'b1;
                        if (data[0] && r_len != 16'd0) begin
                            r_busy    <= 1'b1;
                            r_done    <= 1'b0;
                            r_bus_req <= 1'b1;
                            r_state   <= REQ;
                        end
                    end
                end
            end
            // FSM updates come after slave writes so a RELEASE DONE-set beats a same-cycle clear
            case (r_state)
                REQ: if (bus.bus_gnt) begin
                    r_state  <= RD;
                    r_cnt    <= '0;
                    r_m_addr <= r_src;
                    r_m_cs_  <= 1'b0;
                    r_m_oe_  <= 1'b0;
                end
                RD: if (r_cnt == 8'(RD_WAIT)) begin
                    r_state   <= WR;
                    r_cnt     <= '0;
                    r_m_wdata <= bus.m_rdata;
                    r_m_addr  <= r_dst;
                    r_m_oe_   <= 1'b1;
                    r_m_we_   <= 1'b0;
                    r_m_drive <= 1'b1;
                end else r_cnt <= r_cnt + 8'd1;
                WR: if (r_cnt == 8'(WR_WAIT)) begin
                    r_state <= WR_HOLD;
                    r_m_we_ <= 1'b1;
                end else r_cnt <= r_cnt + 8'd1;
                WR_HOLD: begin
                    r_state   <= NEXT;
                    r_m_cs_   <= 1'b1;
                    r_m_drive <= 1'b0;
                end
                NEXT: begin
                    r_len <= r_len - 16'd1;
                    r_src <= w_src_nx;
                    r_dst <= w_dst_nx;
                    if (r_len == 16'd1) begin
                        r_state   <= RELEASE;
                        r_bus_req <= 1'b0;
                    end else if (bus.bus_gnt) begin
                        r_state  <= RD;
                        r_cnt    <= '0;
                        r_m_addr <= w_src_nx;
                        r_m_cs_  <= 1'b0;
                        r_m_oe_  <= 1'b0;
                    end else r_state <= REQ;
                end
                RELEASE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: directed DMA copies against a synchronous RAM model, with write/read scoreboards.
module tb_dma_ctrl;
    logic        clk = 1'b0;
    logic        rst_;
    logic [7:0]  tb_d;
    logic        tb_de;
    wire  [7:0]  data;
    logic        rd_act;
    logic [7:0]  mem [0:63];
    logic [39:0] q_wr[$];
    logic [15:0] q_rd[$];
    logic [39:0] w_pop;
    logic [15:0] r_pop;
    bit          irq_q;
    int          n_chk, n_err, req_cyc, irq_rise, n, req0, irq0;
    logic        bad;

    dma_ctrl_if bus();
    dma_ctrl dut (.clk(clk), .rst_(rst_), .data(data), .bus(bus));

    assign data = tb_de ? tb_d : 8'hzz;
    always #5 clk = ~clk;

    function automatic int idx(input logic [31:0] a);
        return int'({a[20], a[4:0]});
    endfunction

    // Synchronous RAM: one cycle of read latency
    always @(posedge clk) begin
        if (!bus.m_cs_ && !bus.m_oe_) bus.m_rdata <= mem[idx(bus.m_addr)];
        if (!bus.m_cs_ && !bus.m_we_ && bus.m_drive) mem[idx(bus.m_addr)] <= bus.m_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!bus.m_cs_ && !bus.m_we_) begin
            if (q_wr.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexp_wr: got write %0h=%0h, required none", bus.m_addr, bus.m_wdata);
            end else begin
                w_pop = q_wr.pop_front();
                chk("wr_addr", bus.m_addr, w_pop[39:8]);
                chk("wr_data", {24'h0, bus.m_wdata}, {24'h0, w_pop[7:0]});
                chk("wr_drive", {31'h0, bus.m_drive}, 32'd1);
            end
        end
        if (rd_act) begin
            if (q_rd.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexp_rd: got read %0h, required none", data);
            end else begin
                r_pop = q_rd.pop_front();
                chk($sformatf("rd_%02h", r_pop[15:8]), {24'h0, data}, {24'h0, r_pop[7:0]});
            end
        end
        if (bus.bus_req) req_cyc <= req_cyc + 1;
        if (bus.irq && !irq_q) irq_rise <= irq_rise + 1;
        irq_q <= bus.irq;
    end

    task automatic tick(input int k = 1);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic strobe_wr(input logic [7:0] a, input logic [7:0] d);
        bus.addr = a; tb_d = d; tb_de = 1'b1; bus.cs_ = 1'b0; bus.we_ = 1'b0;
        tick();
        bus.cs_ = 1'b1; bus.we_ = 1'b1; tb_de = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        strobe_wr(a, d);
        tick();
    endtask

    task automatic rd_reg(input logic [7:0] a, input logic [7:0] e);
        q_rd.push_back({a, e});
        bus.addr = a; bus.cs_ = 1'b0; bus.oe_ = 1'b0; rd_act = 1'b1;
        tick();
        bus.cs_ = 1'b1; bus.oe_ = 1'b1; rd_act = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        bus.addr = 8'h0B; bus.cs_ = 1'b0; bus.oe_ = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            if (!data[0]) break;
        end
        if (data[0]) begin
            n_chk++;
            n_err++;
            $display("FAIL busy_timeout: got busy after %0d cycles, required idle", cyc);
        end
        bus.cs_ = 1'b1; bus.oe_ = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ = 1'b0; tb_de = 1'b0; tb_d = 8'h00; rd_act = 1'b0;
        bus.addr = 8'h00; bus.cs_ = 1'b1; bus.oe_ = 1'b1; bus.we_ = 1'b1;
        bus.bus_gnt = 1'b0; bus.m_rdata = 8'h00;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[16] = 8'hA5; mem[17] = 8'h5A; mem[18] = 8'h3C; mem[19] = 8'hC3;
        tick(2);
        rst_ = 1'b1;
        tick();
        chk("rst_bus_req", {31'h0, bus.bus_req}, 32'd0);
        chk("rst_m_cs", {31'h0, bus.m_cs_}, 32'd1);
        chk("rst_m_we", {31'h0, bus.m_we_}, 32'd1);
        chk("rst_m_drive", {31'h0, bus.m_drive}, 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'd0);
        chk("rst_irq", {31'h0, bus.irq}, 32'd0);
        rd_reg(8'h0B, 8'h00);

        wr_reg(8'h00, 8'h10); wr_reg(8'h01, 8'h00); wr_reg(8'h02, 8'h00); wr_reg(8'h03, 8'h00);
        wr_reg(8'h04, 8'h00); wr_reg(8'h05, 8'h00); wr_reg(8'h06, 8'h10); wr_reg(8'h07, 8'h00);
        wr_reg(8'h08, 8'h03); wr_reg(8'h09, 8'h00);
        rd_reg(8'h00, 8'h10); rd_reg(8'h01, 8'h00); rd_reg(8'h02, 8'h00); rd_reg(8'h03, 8'h00);
        rd_reg(8'h04, 8'h00); rd_reg(8'h05, 8'h00); rd_reg(8'h06, 8'h10); rd_reg(8'h07, 8'h00);
        rd_reg(8'h08, 8'h03); rd_reg(8'h09, 8'h00); rd_reg(8'h0C, 8'h00);

        // Three-byte copy with immediate grant
        bus.bus_gnt = 1'b1;
        q_wr.push_back({32'h00100000, 8'hA5});
        q_wr.push_back({32'h00100001, 8'h5A});
        q_wr.push_back({32'h00100002, 8'h3C});
        strobe_wr(8'h0A, 8'h03);
        bus.addr = 8'h0B; bus.cs_ = 1'b0; bus.oe_ = 1'b0;
        #1;
        chk("busy_set", {24'h0, data}, 32'h01);
        wait_idle(n);
        chk("busy_fall_cycles", n, 17);
        tick();
        chk("irq_set", {31'h0, bus.irq}, 32'd1);
        rd_reg(8'h0B, 8'h02);
        rd_reg(8'h0A, 8'h02);
        rd_reg(8'h00, 8'h13);
        rd_reg(8'h04, 8'h03);
        rd_reg(8'h08, 8'h00);
        chk("mem_100002", {24'h0, mem[idx(32'h00100002)]}, 32'h3C);
        wr_reg(8'h0B, 8'h02);
        chk("irq_clear", {31'h0, bus.irq}, 32'd0);

        // Grant held off for 20 cycles
        bus.bus_gnt = 1'b0;
        wr_reg(8'h00, 8'h10); wr_reg(8'h04, 8'h08); wr_reg(8'h08, 8'h01);
        q_wr.push_back({32'h00100008, 8'hA5});
        strobe_wr(8'h0A, 8'h03);
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (!bus.bus_req || !bus.m_cs_) bad = 1'b1;
        end
        chk("gnt_wait", {31'h0, bad}, 32'd0);
        bus.bus_gnt = 1'b1;
        tick();
        chk("gnt_start_cs", {31'h0, bus.m_cs_}, 32'd0);
        chk("gnt_start_oe", {31'h0, bus.m_oe_}, 32'd0);
        chk("gnt_start_addr", bus.m_addr, 32'h10);
        wait_idle(n);
        wr_reg(8'h0B, 8'h02);

        // LEN=0 start
        req0 = req_cyc;
        wr_reg(8'h0A, 8'h01);
        rd_reg(8'h0B, 8'h02);
        rd_reg(8'h0A, 8'h00);
        tick(3);
        chk("len0_no_req", req_cyc - req0, 0);
        wr_reg(8'h0B, 8'h02);

        // DST_FIXED, four bytes to one address
        wr_reg(8'h00, 8'h10); wr_reg(8'h04, 8'h04); wr_reg(8'h08, 8'h04);
        q_wr.push_back({32'h00100004, 8'hA5});
        q_wr.push_back({32'h00100004, 8'h5A});
        q_wr.push_back({32'h00100004, 8'h3C});
        q_wr.push_back({32'h00100004, 8'hC3});
        strobe_wr(8'h0A, 8'h09);
        wait_idle(n);
        chk("fixed_cycles", n, 22);
        rd_reg(8'h04, 8'h04); rd_reg(8'h06, 8'h10);
        rd_reg(8'h00, 8'h14); rd_reg(8'h0A, 8'h08);
        chk("mem_fixed", {24'h0, mem[idx(32'h00100004)]}, 32'hC3);
        wr_reg(8'h0A, 8'h00);
        wr_reg(8'h0B, 8'h02);

        // Writes while busy are ignored
        wr_reg(8'h00, 8'h10); wr_reg(8'h04, 8'h10); wr_reg(8'h08, 8'h02);
        q_wr.push_back({32'h00100010, 8'hA5});
        q_wr.push_back({32'h00100011, 8'h5A});
        irq0 = irq_rise;
        strobe_wr(8'h0A, 8'h03);
        wr_reg(8'h08, 8'h09); wr_reg(8'h09, 8'h00); wr_reg(8'h0A, 8'h03); wr_reg(8'h00, 8'h40);
        wait_idle(n);
        tick(20);
        rd_reg(8'h08, 8'h00); rd_reg(8'h00, 8'h12); rd_reg(8'h0B, 8'h02);
        chk("busy_one_irq", irq_rise - irq0, 1);
        chk("busy_no_restart", {31'h0, bus.bus_req}, 32'd0);
        wr_reg(8'h0B, 8'h02);

        // Reset during WR
        wr_reg(8'h00, 8'h10); wr_reg(8'h04, 8'h30); wr_reg(8'h08, 8'h03);
        q_wr.push_back({32'h00100030, 8'hA5});
        strobe_wr(8'h0A, 8'h01);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!bus.m_we_) break;
        end
        chk("reached_wr", {31'h0, bus.m_we_}, 32'd0);
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        chk("mid_rst_bus_req", {31'h0, bus.bus_req}, 32'd0);
        chk("mid_rst_m_we", {31'h0, bus.m_we_}, 32'd1);
        chk("mid_rst_m_drive", {31'h0, bus.m_drive}, 32'd0);
        chk("mid_rst_m_cs", {31'h0, bus.m_cs_}, 32'd1);
        rd_reg(8'h0B, 8'h00); rd_reg(8'h00, 8'h00); rd_reg(8'h08, 8'h00);

        // A held-low DONE-clear strobe clears only once, so a later DONE survives
        wr_reg(8'h00, 8'h10); wr_reg(8'h04, 8'h40); wr_reg(8'h06, 8'h10); wr_reg(8'h08, 8'h01);
        q_wr.push_back({32'h00100040, 8'hA5});
        strobe_wr(8'h0A, 8'h01);
        bus.addr = 8'h0B; tb_d = 8'h02; tb_de = 1'b1; bus.cs_ = 1'b0; bus.we_ = 1'b0;
        tick(10);
        bus.cs_ = 1'b1; bus.we_ = 1'b1; tb_de = 1'b0;
        tick();
        rd_reg(8'h0B, 8'h02);

        chk("wr_queue_empty", q_wr.size(), 0);
        chk("rd_queue_empty", q_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
